// File: rtl/reg_adrs_seq.sv
// Register-address sequencer: emits a counted, wrapping, optionally descending
// run of register-file addresses. Optional macro SKIP_ZERO_EN never emits address 0.
module reg_adrs_seq #(
  parameter int ADRS_W       = 3,
  parameter int NUM_REGS     = 8,
  parameter int DEFAULT_ADRS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADRS_W-1:0] first_adrs,
  input  logic [ADRS_W:0]   count,
  input  logic              dir,
  input  logic              stall,
  input  logic              abort,
  output logic [ADRS_W-1:0] adrs_out,
  output logic              adrs_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADRS_W-1:0] LAST_ADRS  = ADRS_W'(NUM_REGS - 1);
  localparam logic [ADRS_W-1:0] DFLT_ADRS  = ADRS_W'(DEFAULT_ADRS);
  localparam logic [ADRS_W:0]   NUM_REGS_C = (ADRS_W + 1)'(NUM_REGS);
`ifdef SKIP_ZERO_EN
  localparam logic [ADRS_W:0]   MAX_CNT    = (ADRS_W + 1)'(NUM_REGS - 1);
`else
  localparam logic [ADRS_W:0]   MAX_CNT    = (ADRS_W + 1)'(NUM_REGS);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic [ADRS_W:0]     remaining, remaining_n;
  logic                dir_q, dir_n;
  logic [ADRS_W-1:0]   adrs_n;
  logic                valid_n, busy_n, done_n, err_n;
  logic [ADRS_W-1:0]   start_adrs;
  logic [ADRS_W:0]     sat_count;
  logic                bad_first;

  // Modulo-NUM_REGS step; with zero skipping a landing on 0 moves one more step.
  function automatic logic [ADRS_W-1:0] step_adrs(input logic [ADRS_W-1:0] a,
                                                   input logic down);
    logic [ADRS_W-1:0] n;
    if (down) n = (a == '0) ? LAST_ADRS : a - ADRS_W'(1);
    else      n = (a == LAST_ADRS) ? '0 : a + ADRS_W'(1);
`ifdef SKIP_ZERO_EN
    if (n == '0) n = down ? LAST_ADRS : ADRS_W'(1);
`endif
    return n;
  endfunction

  always_comb begin
    bad_first = ({1'b0, first_adrs} >= NUM_REGS_C);
    sat_count = (count > MAX_CNT) ? MAX_CNT : count;
`ifdef SKIP_ZERO_EN
    start_adrs = (first_adrs == '0) ? step_adrs('0, dir) : first_adrs;
`else
    start_adrs = first_adrs;
`endif
  end

  always_comb begin
    state_n     = state;
    adrs_n      = adrs_out;
    remaining_n = remaining;
    dir_n       = dir_q;
    valid_n     = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        adrs_n = DFLT_ADRS;
        if (start) begin
          if (bad_first) begin
            err_n = 1'b1;
          end else if (count == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n     = RUN;
            adrs_n      = start_adrs;
            remaining_n = sat_count - (ADRS_W + 1)'(1);
            dir_n       = dir;
            valid_n     = 1'b1;
            busy_n      = 1'b1;
          end
        end
      end
      RUN: begin
        // abort wins over stall, stall wins over advancing
        if (abort) begin
          state_n = IDLE;
          adrs_n  = DFLT_ADRS;
        end else if (stall) begin
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end else if (remaining == '0) begin
          state_n = DONE;
          adrs_n  = DFLT_ADRS;
          done_n  = 1'b1;
        end else begin
          adrs_n      = step_adrs(adrs_out, dir_q);
          remaining_n = remaining - (ADRS_W + 1)'(1);
          valid_n     = 1'b1;
          busy_n      = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        adrs_n  = DFLT_ADRS;
      end
      default: begin
        state_n = IDLE;
        adrs_n  = DFLT_ADRS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      dir_q      <= 1'b0;
      adrs_out   <= DFLT_ADRS;
      adrs_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      dir_q      <= dir_n;
      adrs_out   <= adrs_n;
      adrs_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_reg_adrs_seq.sv
// Directed self-checking bench for reg_adrs_seq: one 8-register and one
// 6-register instance, expectations hand-computed (SKIP_ZERO_EN aware).
module tb_reg_adrs_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start6;
  logic [2:0] first_adrs;
  logic [3:0] count;
  logic       dir, stall, abort;

  logic [2:0] adrs8, adrs6;
  logic       valid8, busy8, done8, err8;
  logic       valid6, busy6, done6, err6;

  int testCount = 0;
  int failCount = 0;

  logic [2:0] expSeq [0:7];
  int         expLen;

  always #5 clk = ~clk;

  reg_adrs_seq #(.ADRS_W(3), .NUM_REGS(8), .DEFAULT_ADRS(0)) dut (
    .clk(clk), .reset(reset), .start(start), .first_adrs(first_adrs),
    .count(count), .dir(dir), .stall(stall), .abort(abort),
    .adrs_out(adrs8), .adrs_valid(valid8), .busy(busy8), .done(done8), .err(err8)
  );

  reg_adrs_seq #(.ADRS_W(3), .NUM_REGS(6), .DEFAULT_ADRS(0)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .first_adrs(first_adrs),
    .count(count), .dir(dir), .stall(stall), .abort(abort),
    .adrs_out(adrs6), .adrs_valid(valid6), .busy(busy6), .done(done6), .err(err6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic s6, input logic [2:0] f,
                               input logic [3:0] c, input logic d,
                               input logic st, input logic ab);
    start      = s;
    start6     = s6;
    first_adrs = f;
    count      = c;
    dir        = d;
    stall      = st;
    abort      = ab;
  endtask

  task automatic idleInputs();
    start  = 1'b0;
    start6 = 1'b0;
    stall  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input bit use6, input logic [2:0] eAdrs,
                             input logic eValid, input logic eBusy,
                             input logic eDone, input logic eErr);
    logic [2:0] oAdrs;
    logic       oValid, oBusy, oDone, oErr;
    oAdrs  = use6 ? adrs6  : adrs8;
    oValid = use6 ? valid6 : valid8;
    oBusy  = use6 ? busy6  : busy8;
    oDone  = use6 ? done6  : done8;
    oErr   = use6 ? err6   : err8;
    testCount += 5;
    assert (oAdrs === eAdrs) else begin
      failCount++;
      $error("[TB] FAIL %s adrs_out: observed %0d expected %0d", tag, oAdrs, eAdrs);
    end
    assert (oValid === eValid) else begin
      failCount++;
      $error("[TB] FAIL %s adrs_valid: observed %b expected %b", tag, oValid, eValid);
    end
    assert (oBusy === eBusy) else begin
      failCount++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, oBusy, eBusy);
    end
    assert (oDone === eDone) else begin
      failCount++;
      $error("[TB] FAIL %s done: observed %b expected %b", tag, oDone, eDone);
    end
    assert (oErr === eErr) else begin
      failCount++;
      $error("[TB] FAIL %s err: observed %b expected %b", tag, oErr, eErr);
    end
  endtask

  task automatic setSeq4(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d);
    expSeq[0] = a; expSeq[1] = b; expSeq[2] = c; expSeq[3] = d;
    expLen = 4;
  endtask

  // Caller has just driven a start; walks the expected addresses, then done, then idle.
  task automatic runAndCheck(input string tag, input bit use6);
    tick();
    idleInputs();
    for (int i = 0; i < expLen; i++) begin
      checkOutput($sformatf("%s_a%0d", tag, i), use6, expSeq[i], 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkOutput({tag, "_done"}, use6, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput({tag, "_idle"}, use6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset8", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset6", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'd2, 4'd4, 1'b0, 1'b0, 1'b0);
    setSeq4(3'd2, 3'd3, 3'd4, 3'd5);
    runAndCheck("asc", 1'b0);

    applyStimulus(1'b1, 1'b0, 3'd6, 4'd4, 1'b0, 1'b0, 1'b0);
`ifdef SKIP_ZERO_EN
    setSeq4(3'd6, 3'd7, 3'd1, 3'd2);
`else
    setSeq4(3'd6, 3'd7, 3'd0, 3'd1);
`endif
    runAndCheck("wrapup", 1'b0);

    applyStimulus(1'b1, 1'b0, 3'd1, 4'd4, 1'b1, 1'b0, 1'b0);
`ifdef SKIP_ZERO_EN
    setSeq4(3'd1, 3'd7, 3'd6, 3'd5);
`else
    setSeq4(3'd1, 3'd0, 3'd7, 3'd6);
`endif
    runAndCheck("wrapdn", 1'b0);

    // stall for two cycles after the first address; a start during RUN is ignored
    applyStimulus(1'b1, 1'b0, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd7, 4'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("stall_c1", 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_c2", 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_c3", 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd7, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_a4", 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    idleInputs();
    tick();
    checkOutput("stall_a5", 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stall_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // abort with stall also high on the second address, then restart at once
    applyStimulus(1'b1, 1'b0, 3'd1, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("abort_a0", 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("abort_a1", 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd1, 4'd5, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("abort_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd4, 4'd1, 1'b0, 1'b0, 1'b1);
    expSeq[0] = 3'd4;
    expLen = 1;
    runAndCheck("restart", 1'b0);

    applyStimulus(1'b1, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    expLen = 0;
    runAndCheck("count0", 1'b0);

    applyStimulus(1'b0, 1'b1, 3'd6, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("err6", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("err6_dut8", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("err6_idle", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 3'd1, 4'd3, 1'b1, 1'b0, 1'b0);
`ifdef SKIP_ZERO_EN
    setSeq4(3'd1, 3'd5, 3'd4, 3'd0);
`else
    setSeq4(3'd1, 3'd0, 3'd5, 3'd0);
`endif
    expLen = 3;
    runAndCheck("dn6", 1'b1);

    applyStimulus(1'b1, 1'b0, 3'd3, 4'd15, 1'b0, 1'b0, 1'b0);
    expSeq[0] = 3'd3; expSeq[1] = 3'd4; expSeq[2] = 3'd5; expSeq[3] = 3'd6;
    expSeq[4] = 3'd7;
`ifdef SKIP_ZERO_EN
    expSeq[5] = 3'd1; expSeq[6] = 3'd2; expSeq[7] = 3'd0;
    expLen = 7;
`else
    expSeq[5] = 3'd0; expSeq[6] = 3'd1; expSeq[7] = 3'd2;
    expLen = 8;
`endif
    runAndCheck("sat15", 1'b0);

    // reset in the middle of a run at address 5
    applyStimulus(1'b1, 1'b0, 3'd3, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("rst_a0", 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_a2", 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("rst_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
